memory_stage: RTL and testbench

MEMORY_STAGE -- requirements
Module: memory_stage

---
 rtl/memory_stage_if.sv | 20 ++
 rtl/memory_stage.sv | 183 ++++++++++++++++++
 tb/tb_memory_stage.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/memory_stage_if.sv
// Data-memory request/response bus between the memory stage (master) and the data memory (slave).
interface memory_stage_if;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [3:0]  dm_be;
    logic        dm_ack;
    logic [31:0] dm_rdata;

    modport master (
        output dm_req, dm_we, dm_addr, dm_wdata, dm_be,
        input  dm_ack, dm_rdata
    );

    modport slave (
        input  dm_req, dm_we, dm_addr, dm_wdata, dm_be,
        output dm_ack, dm_rdata
    );
endinterface

// File: rtl/memory_stage.sv
// Pipeline memory stage: pass-through ops retire in one cycle, loads/stores go to data memory and wait for dm_ack.
// Optional build macro MEM_ALIGN_CHECK_EN traps misaligned half/word accesses instead of issuing them.
module memory_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] alu_o,
    input  logic [31:0] rt_data,
    input  logic [31:0] insn,
    input  logic        rwe,
    input  logic        rwd,
    input  logic        rdst,
    input  logic        dmwe,
    input  logic [1:0]  mem_size,
    input  logic        mem_sign,
    memory_stage_if.master dm,
    output logic        wb_valid,
    output logic [31:0] wb_o,
    output logic [31:0] wb_d,
    output logic [31:0] wb_insn,
    output logic        wb_rwe,
    output logic        wb_rwd,
    output logic        wb_rdst,
    output logic        misalign
);
    typedef enum logic {IDLE, WAIT} state_t;

    state_t      state_q, state_d;
    logic        rdy_q;
    logic        dm_we_q;
    logic [31:0] dm_addr_q, dm_wdata_q;
    logic [3:0]  dm_be_q;
    logic [31:0] p_alu_q, p_insn_q;
    logic        p_rwe_q, p_rwd_q, p_rdst_q, p_st_q, p_sign_q;
    logic [1:0]  p_size_q;
    logic        wb_valid_q, wb_rwe_q, wb_rwd_q, wb_rdst_q, misalign_q;
    logic [31:0] wb_o_q, wb_d_q, wb_insn_q;

    logic        accept, is_mem, mis_c, go_mem, done_mem;
    logic [3:0]  be_c;
    logic [31:0] wdata_c, ld_c;
    logic [7:0]  bsel;
    logic [15:0] hsel;

    assign accept   = in_valid && rdy_q;
    assign is_mem   = rwd || dmwe;
`ifdef MEM_ALIGN_CHECK_EN
    assign mis_c    = is_mem && (((mem_size == 2'b01) && alu_o[0]) ||
                                 (mem_size[1] && (alu_o[1:0] != 2'b00)));
`else
    assign mis_c    = 1'b0;
`endif
    assign go_mem   = accept && is_mem && !mis_c;
    assign done_mem = (state_q == WAIT) && dm.dm_ack;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // dm_ack outside WAIT never moves the FSM, so a stray ack in IDLE is dropped
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (go_mem)      state_d = WAIT;
            WAIT:    if (dm.dm_ack)   state_d = IDLE;
            default:                  state_d = IDLE;
        endcase
    end

    always_comb begin
        be_c    = 4'b1111;
        wdata_c = rt_data;
        case (mem_size)
            2'b00: begin
                be_c    = 4'b0001 << alu_o[1:0];
                wdata_c = {4{rt_data[7:0]}};
            end
            2'b01: begin
                be_c    = alu_o[1] ? 4'b1100 : 4'b0011;
                wdata_c = {2{rt_data[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        bsel = dm.dm_rdata[7:0];
        case (p_alu_q[1:0])
            2'd1:    bsel = dm.dm_rdata[15:8];
            2'd2:    bsel = dm.dm_rdata[23:16];
            2'd3:    bsel = dm.dm_rdata[31:24];
            default: ;
        endcase
        hsel = p_alu_q[1] ? dm.dm_rdata[31:16] : dm.dm_rdata[15:0];
        ld_c = dm.dm_rdata;
        case (p_size_q)
            2'b00:   ld_c = {{24{p_sign_q & bsel[7]}}, bsel};
            2'b01:   ld_c = {{16{p_sign_q & hsel[15]}}, hsel};
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_q      <= 1'b0;
            dm_we_q    <= 1'b0;
            dm_addr_q  <= '0;
            dm_wdata_q <= '0;
            dm_be_q    <= '0;
            p_alu_q    <= '0;
            p_insn_q   <= '0;
            p_rwe_q    <= 1'b0;
            p_rwd_q    <= 1'b0;
            p_rdst_q   <= 1'b0;
            p_st_q     <= 1'b0;
            p_sign_q   <= 1'b0;
            p_size_q   <= '0;
            wb_valid_q <= 1'b0;
            wb_o_q     <= '0;
            wb_d_q     <= '0;
            wb_insn_q  <= '0;
            wb_rwe_q   <= 1'b0;
            wb_rwd_q   <= 1'b0;
            wb_rdst_q  <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            rdy_q      <= (state_d == IDLE);
            wb_valid_q <= 1'b0;
            misalign_q <= 1'b0;
            if (go_mem) begin
                dm_we_q    <= dmwe;
                dm_addr_q  <= {alu_o[31:2], 2'b00};
                dm_wdata_q <= wdata_c;
                dm_be_q    <= be_c;
                p_alu_q    <= alu_o;
                p_insn_q   <= insn;
                p_rwe_q    <= rwe;
                p_rwd_q    <= rwd;
                p_rdst_q   <= rdst;
                p_st_q     <= dmwe;
                p_sign_q   <= mem_sign;
                p_size_q   <= mem_size;
            end
            // Pass-through and trapped misaligned ops retire straight from IDLE
            if (accept && !go_mem) begin
                wb_valid_q <= 1'b1;
                wb_o_q     <= alu_o;
                wb_d_q     <= '0;
                wb_insn_q  <= insn;
                wb_rwe_q   <= rwe && !mis_c;
                wb_rwd_q   <= rwd;
                wb_rdst_q  <= rdst;
                misalign_q <= mis_c;
            end
            if (done_mem) begin
                wb_valid_q <= 1'b1;
                wb_o_q     <= p_alu_q;
                wb_d_q     <= p_st_q ? 32'h0 : ld_c;
                wb_insn_q  <= p_insn_q;
                wb_rwe_q   <= p_rwe_q && !p_st_q;
                wb_rwd_q   <= p_rwd_q;
                wb_rdst_q  <= p_rdst_q;
            end
        end
    end

    assign in_ready    = rdy_q;
    assign dm.dm_req   = (state_q == WAIT);
    assign dm.dm_we    = dm_we_q;
    assign dm.dm_addr  = dm_addr_q;
    assign dm.dm_wdata = dm_wdata_q;
    assign dm.dm_be    = dm_be_q;
    assign wb_valid    = wb_valid_q;
    assign wb_o        = wb_o_q;
    assign wb_d        = wb_d_q;
    assign wb_insn     = wb_insn_q;
    assign wb_rwe      = wb_rwe_q;
    assign wb_rwd      = wb_rwd_q;
    assign wb_rdst     = wb_rdst_q;
    assign misalign    = misalign_q;
endmodule

// File: tb/tb_memory_stage.sv
// Scoreboard bench for memory_stage: expected writebacks queued at issue, popped on wb_valid.
module tb_memory_stage;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid, in_ready;
    logic [31:0] alu_o, rt_data, insn;
    logic        rwe, rwd, rdst, dmwe, mem_sign;
    logic [1:0]  mem_size;
    logic        wb_valid, wb_rwe, wb_rwd, wb_rdst, misalign;
    logic [31:0] wb_o, wb_d, wb_insn;

    always #5 clk = ~clk;

    memory_stage_if dm_bus();

    memory_stage dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .alu_o(alu_o), .rt_data(rt_data), .insn(insn),
        .rwe(rwe), .rwd(rwd), .rdst(rdst), .dmwe(dmwe),
        .mem_size(mem_size), .mem_sign(mem_sign), .dm(dm_bus),
        .wb_valid(wb_valid), .wb_o(wb_o), .wb_d(wb_d), .wb_insn(wb_insn),
        .wb_rwe(wb_rwe), .wb_rwd(wb_rwd), .wb_rdst(wb_rdst), .misalign(misalign)
    );

    typedef struct {
        logic [31:0] o, d, insn;
        logic        rwe, rwd, rdst, mis, mem;
        int          t0, lat;
    } exp_t;

    exp_t        sbq[$];
    int          total = 0, bad = 0, pcyc = 0;
    int          ack_delay = 0;
    logic [31:0] rd_val = '0, exp_addr = '0, exp_wd = '0;
    logic [3:0]  exp_be = '0;
    logic        exp_we = 1'b0, req_seen = 1'b0;

    always @(posedge clk) pcyc++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s obs=%h exp=%h t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Memory model: acks after ack_delay cycles of dm_req, checks the request fields each cycle
    initial begin
        int cnt = 0;
        dm_bus.dm_ack   = 1'b0;
        dm_bus.dm_rdata = '0;
        forever begin
            @(negedge clk);
            if (dm_bus.dm_ack) dm_bus.dm_ack = 1'b0;
            else if (dm_bus.dm_req) begin
                req_seen = 1'b1;
                chk("dm_addr", dm_bus.dm_addr, exp_addr);
                chk("dm_be", {28'h0, dm_bus.dm_be}, {28'h0, exp_be});
                chk("dm_wdata", dm_bus.dm_wdata, exp_wd);
                chk("dm_we", {31'h0, dm_bus.dm_we}, {31'h0, exp_we});
                chk("rdy_in_wait", {31'h0, in_ready}, 32'h0);
                if (cnt >= ack_delay) begin
                    dm_bus.dm_ack   = 1'b1;
                    dm_bus.dm_rdata = rd_val;
                    cnt = 0;
                end else cnt++;
            end else cnt = 0;
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (wb_valid) begin
                if (sbq.size() == 0) chk("unexp_wb", 32'h1, 32'h0);
                else begin
                    e = sbq.pop_front();
                    chk("wb_o", wb_o, e.o);
                    chk("wb_d", wb_d, e.d);
                    chk("wb_insn", wb_insn, e.insn);
                    chk("wb_rwe", {31'h0, wb_rwe}, {31'h0, e.rwe});
                    chk("wb_rwd", {31'h0, wb_rwd}, {31'h0, e.rwd});
                    chk("wb_rdst", {31'h0, wb_rdst}, {31'h0, e.rdst});
                    chk("misalign", {31'h0, misalign}, {31'h0, e.mis});
                    chk("dm_req_seen", {31'h0, req_seen}, {31'h0, e.mem});
                    if (e.lat >= 0) chk("latency", 32'(pcyc - e.t0), 32'(e.lat));
                    req_seen = 1'b0;
                end
            end
        end
    end

    // Called at a negedge; issues one op and returns at the following negedge
    task automatic send(input logic [31:0] alu, rt, ins, input logic we_in, ld, dst, st,
                        input logic [1:0] sz, input logic sg, input int dly,
                        input logic [31:0] rdata, e_d, e_addr, e_wd, input logic [3:0] e_be,
                        input logic mis, input int lat, input bit push = 1'b1);
        exp_t e;
        int   n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("rdy_timeout", 32'h0, 32'h1);
        alu_o = alu; rt_data = rt; insn = ins;
        rwe = we_in; rwd = ld; rdst = dst; dmwe = st;
        mem_size = sz; mem_sign = sg; in_valid = 1'b1;
        ack_delay = dly; rd_val = rdata;
        exp_addr = e_addr; exp_wd = e_wd; exp_be = e_be; exp_we = st;
        if (push) begin
            e.o = alu; e.d = e_d; e.insn = ins;
            e.rwe = we_in && !st && !mis; e.rwd = ld; e.rdst = dst;
            e.mis = mis; e.mem = (ld || st) && !mis;
            e.t0 = pcyc; e.lat = lat;
            sbq.push_back(e);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sbq.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 32'(sbq.size()), 32'h0);
    endtask

    initial begin
        int wcnt;
        logic rq;
        in_valid = 1'b0; alu_o = '0; rt_data = '0; insn = '0;
        rwe = 1'b0; rwd = 1'b0; rdst = 1'b0; dmwe = 1'b0; mem_size = '0; mem_sign = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", {31'h0, in_ready}, 32'h0);
        chk("rst_dm_req", {31'h0, dm_bus.dm_req}, 32'h0);
        chk("rst_wb_valid", {31'h0, wb_valid}, 32'h0);
        chk("rst_misalign", {31'h0, misalign}, 32'h0);
        chk("rst_wb_o", wb_o, 32'h0);
        chk("rst_dm_addr", dm_bus.dm_addr, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rdy_after_rst", {31'h0, in_ready}, 32'h1);

        send(32'h0000_1234, 32'h0, 32'hA000_0001, 1,0,1,0, 2'b10,0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 4'h0, 0, 1);
        for (int i = 0; i < 3; i++)
            send($urandom, $urandom, 32'hA000_0010 + i, 1'($urandom), 0, 1'($urandom), 0,
                 2'($urandom), 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 4'h0, 0, 1);
        drain();

        send(32'h0000_0103, 32'h0, 32'hB000_0001, 1,1,1,0, 2'b00,1, 3, 32'h80FF_0000,
             32'hFFFF_FF80, 32'h0000_0100, 32'h0, 4'b1000, 0, 5);
        send(32'h0000_0102, 32'hAAAA_BEEF, 32'hB000_0002, 1,0,0,1, 2'b01,0, 1, 32'h0,
             32'h0, 32'h0000_0100, 32'hBEEF_BEEF, 4'b1100, 0, 3);
        send(32'h0000_0200, 32'h0, 32'hB000_0003, 1,1,0,0, 2'b10,0, 0, 32'hDEAD_BEEF,
             32'hDEAD_BEEF, 32'h0000_0200, 32'h0, 4'b1111, 0, 2);
        drain();

        // Stray ack while idle must not retire anything
        #1 dm_bus.dm_ack = 1'b1;
        wcnt = 0; rq = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (wb_valid) wcnt++;
            rq = rq | dm_bus.dm_req;
        end
        chk("idle_ack_wb", 32'(wcnt), 32'h0);
        chk("idle_ack_req", {31'h0, rq}, 32'h0);

        send(32'h0000_0102, 32'h0, 32'hC000_0001, 1,1,0,0, 2'b01,0, 2, 32'h80FF_1234,
             32'h0000_80FF, 32'h0000_0100, 32'h0, 4'b1100, 0, 4);
        send(32'h0000_0100, 32'h0, 32'hC000_0002, 1,1,1,0, 2'b01,1, 1, 32'h1234_8765,
             32'hFFFF_8765, 32'h0000_0100, 32'h0, 4'b0011, 0, 3);
        send(32'h0000_0101, 32'h0, 32'hC000_0003, 1,1,0,0, 2'b00,0, 0, 32'h0000_A500,
             32'h0000_00A5, 32'h0000_0100, 32'h0, 4'b0010, 0, 2);
        send(32'h0000_0001, 32'h0000_0012, 32'hC000_0004, 1,0,0,1, 2'b00,0, 0, 32'h0,
             32'h0, 32'h0, 32'h1212_1212, 4'b0010, 0, 2);
        send(32'h0000_0204, 32'hCAFE_F00D, 32'hC000_0005, 0,0,1,1, 2'b11,0, 2, 32'h0,
             32'h0, 32'h0000_0204, 32'hCAFE_F00D, 4'b1111, 0, 4);
        drain();

        // Reset in the middle of a long access: abandoned, no writeback
        send(32'h0000_0300, 32'h0, 32'hD000_0001, 1,1,0,0, 2'b10,0, 1000, 32'h1,
             32'h0, 32'h0000_0300, 32'h0, 4'b1111, 0, -1, 1'b0);
        repeat (2) @(negedge clk);
        chk("wait_dm_req", {31'h0, dm_bus.dm_req}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("midrst_dm_req", {31'h0, dm_bus.dm_req}, 32'h0);
        chk("midrst_in_ready", {31'h0, in_ready}, 32'h0);
        chk("midrst_dm_be", {28'h0, dm_bus.dm_be}, 32'h0);
        chk("midrst_wb_valid", {31'h0, wb_valid}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        req_seen = 1'b0;
        @(negedge clk);
        chk("rdy_after_midrst", {31'h0, in_ready}, 32'h1);
        send(32'h0000_0404, 32'h0, 32'hD000_0002, 1,1,1,0, 2'b10,0, 1, 32'h5566_7788,
             32'h5566_7788, 32'h0000_0404, 32'h0, 4'b1111, 0, 3);
        drain();

`ifdef MEM_ALIGN_CHECK_EN
        send(32'h0000_0101, 32'h0, 32'hE000_0001, 1,1,0,0, 2'b10,0, 0, 32'h0,
             32'h0, 32'h0, 32'h0, 4'h0, 1, 1);
`else
        send(32'h0000_0101, 32'h0, 32'hE000_0001, 1,1,0,0, 2'b10,0, 0, 32'h1122_3344,
             32'h1122_3344, 32'h0000_0100, 32'h0, 4'b1111, 0, 2);
`endif
        drain();
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
